// File: rtl/escalonador_pc_pkg.sv
`default_nettype none
// ============================================================================
// escalonador_pc_pkg -- scheduler FSM states, next-PC mux codes, output decode
// Rev 1.0
// ============================================================================
package escalonador_pc_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    EXECUTA = 3'd1,
    PAUSA   = 3'd2,
    SALVA   = 3'd3,
    CARREGA = 3'd4
  } estado_t;

  localparam logic [1:0] c_ctrl_seq    = 2'b00;
  localparam logic [1:0] c_ctrl_hold   = 2'b10;
  localparam logic [1:0] c_ctrl_branch = 2'b11;

  typedef struct packed {
    logic [1:0] controle;
    logic       flag_pausa;
    logic       branch_forcado;
  } saida_t;

  // Mux-facing outputs for the state about to be entered.
  function automatic saida_t saida_estado(input estado_t e);
    saida_t s;
    s = '{controle: c_ctrl_hold, flag_pausa: 1'b1, branch_forcado: 1'b0};
    case (e)
      EXECUTA: s = '{controle: c_ctrl_seq,    flag_pausa: 1'b0, branch_forcado: 1'b0};
      CARREGA: s = '{controle: c_ctrl_branch, flag_pausa: 1'b0, branch_forcado: 1'b1};
      default: ;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/escalonador_pc_seletor_rr.sv
`default_nettype none
// ============================================================================
// seletor_rr -- first set mask bit after i_atual, wrapping; i_atual itself last
// Rev 1.0
// ============================================================================
module seletor_rr #(
  parameter int N_CONTEXTOS = 4
) (
  input  logic [N_CONTEXTOS-1:0]         i_mascara,
  input  logic [$clog2(N_CONTEXTOS)-1:0] i_atual,
  output logic [$clog2(N_CONTEXTOS)-1:0] o_proximo,
  output logic                           o_valido
);

  localparam int ID_W = $clog2(N_CONTEXTOS);

  logic [ID_W-1:0] w_idx;

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    o_proximo = '0;
    o_valido  = 1'b0;
    w_idx     = '0;
    for (int k = N_CONTEXTOS; k >= 1; k--) begin
      w_idx = i_atual + ID_W'(k);
      if (i_mascara[w_idx]) begin
        o_proximo = w_idx;
        o_valido  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/escalonador_pc.sv
`default_nettype none
// ============================================================================
// escalonador_pc -- round-robin time-sliced hardware context scheduler
// Rev 1.0
// ============================================================================
module escalonador_pc
  import escalonador_pc_pkg::*;
#(
  parameter int N_CONTEXTOS = 4,
  parameter int QUANTUM_W   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [QUANTUM_W-1:0]           quantum,
  input  logic                           ativa_contexto,
  input  logic [$clog2(N_CONTEXTOS)-1:0] id_contexto,
  input  logic [31:0]                    pc_inicial,
  input  logic                           fim_contexto,
  input  logic                           branch_pendente,
  input  logic [31:0]                    endereco_atual,
  output logic [1:0]                     controle,
  output logic                           branch_forcado,
  output logic [31:0]                    endereco_contexto,
  output logic                           flag_pausa_contexto,
  output logic [$clog2(N_CONTEXTOS)-1:0] contexto_atual,
  output logic                           aceito
);

  localparam int ID_W = $clog2(N_CONTEXTOS);

  estado_t              r_estado;
  saida_t               r_saida;
  logic [N_CONTEXTOS-1:0] r_ativo;
  logic [31:0]          r_tabela [N_CONTEXTOS];
  logic [QUANTUM_W-1:0] r_contador;
  logic [QUANTUM_W-1:0] r_quantum;
  logic [ID_W-1:0]      r_atual;
  logic [31:0]          r_end_ctx;
  logic                 r_aceito;

  logic [ID_W-1:0]      w_prox;
  logic                 w_valido;
  logic                 w_outro;
  logic                 w_aceita;
  logic [QUANTUM_W-1:0] w_limite;

  seletor_rr #(.N_CONTEXTOS(N_CONTEXTOS)) u_seletor (
    .i_mascara (r_ativo),
    .i_atual   (r_atual),
    .o_proximo (w_prox),
    .o_valido  (w_valido)
  );

  // The running context is always active in EXECUTA, so a different pick means
  // at least one other context is waiting.
  assign w_outro  = w_valido && (w_prox != r_atual);
  assign w_limite = (r_quantum == '0) ? '0 : r_quantum - QUANTUM_W'(1);
  assign w_aceita = ativa_contexto &&
                    ((r_estado == OCIOSO) ||
                     (((r_estado == EXECUTA) || (r_estado == PAUSA)) && (id_contexto != r_atual)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_saida    <= saida_estado(OCIOSO);
      r_ativo    <= '0;
      r_contador <= '0;
      r_quantum  <= '0;
      r_atual    <= '0;
      r_end_ctx  <= '0;
      r_aceito   <= 1'b0;
      for (int i = 0; i < N_CONTEXTOS; i++) r_tabela[i] <= '0;
    end else begin
      r_aceito <= w_aceita;
      if (w_aceita) begin
        r_tabela[id_contexto] <= pc_inicial;
        r_ativo[id_contexto]  <= 1'b1;
      end
      case (r_estado)
        OCIOSO: begin
          if (w_aceita) begin
            r_estado  <= CARREGA;
            r_saida   <= saida_estado(CARREGA);
            r_atual   <= id_contexto;
            r_end_ctx <= pc_inicial;
          end
        end
        CARREGA: begin
          r_estado   <= EXECUTA;
          r_saida    <= saida_estado(EXECUTA);
          r_contador <= '0;
          r_quantum  <= quantum;
        end
        EXECUTA: begin
          if (fim_contexto) begin
            r_ativo[r_atual] <= 1'b0;
            r_estado         <= PAUSA;
            r_saida          <= saida_estado(PAUSA);
          end else if (r_contador == w_limite) begin
            if (w_outro) begin
              r_estado <= PAUSA;
              r_saida  <= saida_estado(PAUSA);
            end else begin
              r_contador <= '0;
              r_quantum  <= quantum;
            end
          end else begin
            r_contador <= r_contador + QUANTUM_W'(1);
          end
        end
        PAUSA: begin
          if (!branch_pendente) begin
            r_estado <= SALVA;
            r_saida  <= saida_estado(SALVA);
          end
        end
        SALVA: begin
          r_tabela[r_atual] <= endereco_atual;
          if (w_valido) begin
            r_estado  <= CARREGA;
            r_saida   <= saida_estado(CARREGA);
            r_atual   <= w_prox;
            r_end_ctx <= (w_prox == r_atual) ? endereco_atual : r_tabela[w_prox];
          end else begin
            r_estado <= OCIOSO;
            r_saida  <= saida_estado(OCIOSO);
          end
        end
        default: begin
          r_estado <= OCIOSO;
          r_saida  <= saida_estado(OCIOSO);
        end
      endcase
    end
  end

  assign controle            = r_saida.controle;
  assign flag_pausa_contexto = r_saida.flag_pausa;
  assign branch_forcado      = r_saida.branch_forcado;
  assign endereco_contexto   = r_end_ctx;
  assign contexto_atual      = r_atual;
  assign aceito              = r_aceito;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_pc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_escalonador_pc -- directed + random stimulus against a slice-level model
// Rev 1.0
// ============================================================================
module tb_escalonador_pc;

  localparam int N   = 4;
  localparam int QW  = 16;
  localparam int IDW = 2;
  localparam int F_OCIOSO = 0, F_EXEC = 1, F_PAUSA = 2, F_SALVA = 3, F_CARREGA = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [QW-1:0] quantum;
  logic          ativa_contexto;
  logic [IDW-1:0] id_contexto;
  logic [31:0]   pc_inicial;
  logic          fim_contexto;
  logic          branch_pendente;
  logic [31:0]   endereco_atual;
  logic [1:0]    controle;
  logic          branch_forcado;
  logic [31:0]   endereco_contexto;
  logic          flag_pausa_contexto;
  logic [IDW-1:0] contexto_atual;
  logic          aceito;

  always #5 clock = ~clock;

  escalonador_pc #(.N_CONTEXTOS(N), .QUANTUM_W(QW)) dut (
    .clock               (clock),
    .reset               (reset),
    .quantum             (quantum),
    .ativa_contexto      (ativa_contexto),
    .id_contexto         (id_contexto),
    .pc_inicial          (pc_inicial),
    .fim_contexto        (fim_contexto),
    .branch_pendente     (branch_pendente),
    .endereco_atual      (endereco_atual),
    .controle            (controle),
    .branch_forcado      (branch_forcado),
    .endereco_contexto   (endereco_contexto),
    .flag_pausa_contexto (flag_pausa_contexto),
    .contexto_atual      (contexto_atual),
    .aceito              (aceito)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase, active set, saved PCs, running id, cycles left in the slice.
  int          m_fase;
  bit          m_ativo [N];
  logic [31:0] m_tab [N];
  int          m_cur;
  int          m_rest;
  logic [31:0] m_end;
  bit          m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    int n_at;
    int base;
    bit found;
    int c;
    acc = ativa_contexto && (m_fase == F_OCIOSO ||
          ((m_fase == F_EXEC || m_fase == F_PAUSA) && int'(id_contexto) != m_cur));
    m_ack = 0;
    if (!reset) begin
      m_fase = F_OCIOSO; m_cur = 0; m_end = 0; m_rest = 0;
      for (int i = 0; i < N; i++) begin m_ativo[i] = 0; m_tab[i] = 0; end
      return;
    end
    n_at = 0;
    for (int i = 0; i < N; i++) n_at += int'(m_ativo[i]);
    case (m_fase)
      F_OCIOSO: if (acc) begin m_fase = F_CARREGA; m_cur = int'(id_contexto); m_end = pc_inicial; end
      F_CARREGA: begin m_fase = F_EXEC; m_rest = (quantum == 0) ? 1 : int'(quantum); end
      F_EXEC: begin
        if (fim_contexto) begin m_ativo[m_cur] = 0; m_fase = F_PAUSA; end
        else if (m_rest == 1) begin
          if (n_at > 1) m_fase = F_PAUSA;
          else m_rest = (quantum == 0) ? 1 : int'(quantum);
        end else m_rest--;
      end
      F_PAUSA: if (!branch_pendente) m_fase = F_SALVA;
      F_SALVA: begin
        m_tab[m_cur] = endereco_atual;
        base = m_cur; found = 0; m_fase = F_OCIOSO;
        for (int k = 1; k <= N; k++) begin
          c = (base + k) % N;
          if (!found && m_ativo[c]) begin
            found = 1; m_cur = c; m_end = m_tab[c]; m_fase = F_CARREGA;
          end
        end
      end
      default: m_fase = F_OCIOSO;
    endcase
    if (acc) begin m_tab[id_contexto] = pc_inicial; m_ativo[id_contexto] = 1; m_ack = 1; end
  endtask

  task automatic tick();
    logic [1:0] e_ctrl;
    @(posedge clock);
    model_edge();
    #1;
    e_ctrl = (m_fase == F_EXEC) ? 2'b00 : (m_fase == F_CARREGA) ? 2'b11 : 2'b10;
    chk("controle", 32'(controle), 32'(e_ctrl));
    chk("branch_forcado", 32'(branch_forcado), 32'(m_fase == F_CARREGA));
    if (m_fase != F_CARREGA)
      chk("flag_pausa", 32'(flag_pausa_contexto), 32'(m_fase != F_EXEC));
    chk("contexto_atual", 32'(contexto_atual), 32'(m_cur));
    chk("endereco_contexto", endereco_contexto, m_end);
    chk("aceito", 32'(aceito), 32'(m_ack));
    endereco_atual = $urandom;
  endtask

  task automatic ativar(input int id, input logic [31:0] pc);
    ativa_contexto = 1'b1; id_contexto = IDW'(id); pc_inicial = pc;
    tick();
    ativa_contexto = 1'b0;
  endtask

  task automatic wait_fase(input int f, input int lim);
    int n = 0;
    while (m_fase != f && n < lim) begin tick(); n++; end
    chk("wait_fase_timeout", 32'(m_fase == f), 32'd1);
  endtask

  // EXECUTA cycles observed between two consecutive CARREGA cycles.
  task automatic medir_fatia(input int esperado);
    int n = 0;
    int lim = 0;
    while (!branch_forcado && lim < 100) begin tick(); lim++; end
    tick();
    while (!branch_forcado && lim < 100) begin
      if (controle == 2'b00) n++;
      tick(); lim++;
    end
    chk("slice_len", 32'(n), 32'(esperado));
  endtask

  initial begin
    int nh;
    int lim;
    int nbad;
    reset = 1'b0; quantum = 16'd4; ativa_contexto = 1'b0; id_contexto = '0;
    pc_inicial = '0; fim_contexto = 1'b0; branch_pendente = 1'b0; endereco_atual = '0;
    m_fase = F_OCIOSO; m_cur = 0; m_rest = 0; m_end = 0; m_ack = 0;
    for (int i = 0; i < N; i++) begin m_ativo[i] = 0; m_tab[i] = 0; end

    // Reset state
    tick(); tick();
    chk("rst_controle", 32'(controle), 32'h2);
    chk("rst_flag", 32'(flag_pausa_contexto), 32'h1);
    chk("rst_endereco", endereco_contexto, 32'h0);
    reset = 1'b1;
    tick();

    // Single activation from idle
    ativar(2, 32'h100);
    chk("act_aceito", 32'(aceito), 32'h1);
    chk("act_carrega_end", endereco_contexto, 32'h100);
    chk("act_carrega_ctrl", 32'(controle), 32'h3);
    tick();
    chk("act_executa_ctrl", 32'(controle), 32'h0);
    repeat (10) tick();

    // Two contexts, quantum 4
    reset = 1'b0; tick(); reset = 1'b1;
    ativar(0, 32'h1000);
    tick();
    ativar(1, 32'h2000);
    medir_fatia(4);
    medir_fatia(4);
    repeat (12) tick();

    // branch_pendente held for 3 PAUSA cycles
    branch_pendente = 1'b1;
    wait_fase(F_PAUSA, 50);
    nh = 1;
    repeat (3) begin tick(); if (flag_pausa_contexto) nh++; end
    branch_pendente = 1'b0;
    lim = 0;
    while (!branch_forcado && lim < 20) begin
      tick(); lim++;
      if (flag_pausa_contexto) nh++;
    end
    chk("hold_cycles", 32'(nh), 32'd5);
    repeat (10) tick();

    // Activation during SALVA is ignored
    wait_fase(F_SALVA, 50);
    ativa_contexto = 1'b1; id_contexto = IDW'(m_cur ^ 1); pc_inicial = 32'hDEAD_BEEF;
    tick();
    ativa_contexto = 1'b0;
    chk("salva_aceito", 32'(aceito), 32'h0);

    // quantum 0 behaves as 1
    quantum = 16'd0;
    medir_fatia(1);
    medir_fatia(1);
    repeat (6) tick();

    // fim_contexto on the quantum expiry cycle retires the context
    quantum = 16'd3;
    lim = 0;
    while (!(m_fase == F_EXEC && m_rest == 1) && lim < 50) begin tick(); lim++; end
    chk("expiry_found", 32'(m_fase == F_EXEC && m_rest == 1), 32'h1);
    fim_contexto = 1'b1; tick(); fim_contexto = 1'b0;
    wait_fase(F_EXEC, 20);
    nbad = 0;
    repeat (10) begin tick(); if (controle != 2'b00) nbad++; end
    chk("solo_no_switch", 32'(nbad), 32'h0);

    // Last active context halts
    fim_contexto = 1'b1; tick(); fim_contexto = 1'b0;
    wait_fase(F_OCIOSO, 20);
    chk("idle_flag", 32'(flag_pausa_contexto), 32'h1);
    chk("idle_controle", 32'(controle), 32'h2);

    // Reset during CARREGA
    ativar(1, 32'h200);
    chk("pre_rst_carrega", 32'(branch_forcado), 32'h1);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst_carrega_end", endereco_contexto, 32'h0);
    chk("rst_carrega_ctrl", 32'(controle), 32'h2);
    tick();

    // Random traffic
    for (int it = 0; it < 800; it++) begin
      ativa_contexto  = ($urandom % 6) == 0;
      id_contexto     = IDW'($urandom % N);
      pc_inicial      = $urandom;
      fim_contexto    = ($urandom % 12) == 0;
      branch_pendente = ($urandom % 3) == 0;
      if (($urandom % 40) == 0) quantum = QW'($urandom % 6);
      reset = ($urandom % 150) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/escalonador_pc.md
ESCALONADOR_PC -- requirements
Module: escalonador_pc

Interface
REQ-001 SHALL have parameter N_CONTEXTOS, default 4, meaning number of hardware contexts (power of 2, 2..8).
REQ-002 SHALL have parameter QUANTUM_W, default 16, meaning width of the time-slice counter.
REQ-003 SHALL have port clock  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 SHALL have port quantum  input  QUANTUM_W  meaning time-slice length in cycles; 0 SHALL be treated as 1.
REQ-006 SHALL have port ativa_contexto  input  1  meaning a one-cycle request to start context id_contexto at pc_inicial.
REQ-007 SHALL have port id_contexto  input  log2(N_CONTEXTOS)  meaning the target context for activation.
REQ-008 SHALL have port pc_inicial  input  32  meaning the start PC for activation.
REQ-009 SHALL have port fim_contexto  input  1  meaning the running context has halted.
REQ-010 SHALL have port branch_pendente  input  1  meaning a branch is in flight, so no PC save is allowed this cycle.
REQ-011 SHALL have port endereco_atual  input  32  meaning the PC to be saved for the running context.
REQ-012 SHALL have port controle  output  2  meaning the next-PC mux select: 00 sequential, 10 hold, 11 branch.
REQ-013 SHALL have port branch_forcado  output  1  meaning forces branch selection on the next-PC mux.
REQ-014 SHALL have port endereco_contexto  output  32  meaning the restored PC, driven on the mux branch address.
REQ-015 SHALL have port flag_pausa_contexto  output  1  meaning holds the PC during a switch or while idle.
REQ-016 SHALL have port contexto_atual  output  log2(N_CONTEXTOS)  meaning the running context id.
REQ-017 SHALL have port aceito  output  1  meaning a registered one-cycle acknowledge of ativa_contexto.

Function
REQ-018 SHALL implement an FSM with states OCIOSO, EXECUTA, PAUSA, SALVA and CARREGA; all outputs SHALL be registered.
REQ-019 SHALL hold a 32-bit saved-PC table and an ativo bit for each context.
REQ-020 In OCIOSO: flag_pausa_contexto=1 and controle=10; on an accepted activation the FSM SHALL load that context and go to CARREGA.
REQ-021 In EXECUTA: controle=00 and flag=0; the counter SHALL increment each cycle.
REQ-022 In EXECUTA, when counter==max(quantum,1)-1 and more than one context is active, the FSM SHALL go to PAUSA; with only one context active, the counter SHALL wrap to 0 with no switch.
REQ-023 In PAUSA: flag=1 and controle=10; the FSM SHALL stay in PAUSA while branch_pendente=1, and go to SALVA in the first cycle where it is 0.
REQ-024 In SALVA: table[contexto_atual] SHALL be loaded with endereco_atual; the next context is the first active one after contexto_atual in round-robin order, modulo N_CONTEXTOS.
REQ-025 CARREGA SHALL last exactly 1 cycle with controle=11, branch_forcado=1, endereco_contexto=table[next] and contexto_atual=next; the FSM SHALL then enter EXECUTA with counter=0.
REQ-026 On fim_contexto in EXECUTA, the current ativo bit SHALL be cleared and the FSM SHALL go to PAUSA regardless of the counter; in SALVA, with no active context left, the FSM SHALL go to OCIOSO.
REQ-027 Activation SHALL be accepted in OCIOSO, EXECUTA and PAUSA (aceito=1 the next cycle) and ignored in SALVA and CARREGA (aceito=0).
REQ-028 Activation of an already-active context SHALL overwrite its PC only; activation of the running context SHALL also be ignored (aceito=0).
REQ-029 When fim_contexto and the quantum expiry occur in the same cycle, fim_contexto SHALL take priority.
REQ-030 A change in quantum SHALL take effect at the next slice start only.

Reset
REQ-031 Under reset the FSM SHALL go to OCIOSO with all ativo=0, table=0, counter=0, contexto_atual=0, controle=10, flag_pausa_contexto=1, branch_forcado=0, endereco_contexto=0 and aceito=0.
REQ-032 Reset asserted mid-switch SHALL abort the switch with no table write.

Structure
REQ-033 The state encodings and the controle codes (00/10/11) SHALL live in a shared package used by the next-PC mux and this block.
REQ-034 The round-robin next-active selector SHALL be a sub-module, seletor_rr (combinational, N_CONTEXTOS-bit mask plus current id -> next id and a valid flag).

Verification
REQ-035 Bench SHALL cover: after reset, activate ctx 2 at pc 0x100 -> aceito, then CARREGA with endereco_contexto=0x100, then EXECUTA.
REQ-036 Bench SHALL cover: ctx 0 and ctx 1 active with quantum=4 -> a switch every 4 cycles, with PCs saved and restored exactly.
REQ-037 Bench SHALL cover: branch_pendente held 3 cycles in PAUSA -> 3 extra hold cycles, and the saved PC is taken after the drop.
REQ-038 Bench SHALL cover: fim_contexto on the last active context -> OCIOSO with flag=1; fim_contexto coinciding with quantum expiry -> the context is retired.
REQ-039 Bench SHALL cover: activation during SALVA -> aceito=0 and the table is unchanged; quantum=0 -> a switch every cycle boundary with 1-cycle slices.
REQ-040 Bench SHALL cover: reset asserted during CARREGA -> OCIOSO next cycle with table=0.
